// File: rtl/serial_pattern_pkg.sv
// Shared types and sizing helpers for the serial pattern transmitter.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } tx_state_e;

  // Width that holds 0..width/2, the most pairs a frame can contain.
  function automatic int cnt_width(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_pair_run_counter.sv
// Predicts the pulses of a two-consecutive-ones detector fed with bit_in.
module pair_run_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  logic run_odd;

  // A detector pulse consumes the pair, so run_odd restarts after each count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run_odd <= 1'b0;
      count   <= '0;
    end else if (bit_en) begin
      if (!bit_in) begin
        run_odd <= 1'b0;
      end else if (run_odd) begin
        run_odd <= 1'b0;
        count   <= count + 1'b1;
      end else begin
        run_odd <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-in/serial-out frame transmitter with trailing zero gap and
// predicted detector pulse count per frame.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int GAP_BITS  = 1,
  parameter  int LSB_FIRST = 0,
  localparam int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = $clog2(GAP_BITS + 1);

  tx_state_e        state;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             accept;

  assign accept = (state == IDLE) && in_valid;

  function automatic logic head(input logic [WIDTH-1:0] d);
    return (LSB_FIRST != 0) ? d[0] : d[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    return (LSB_FIRST != 0) ? (d >> 1) : (d << 1);
  endfunction

  // Outputs are registered: the bit shown in a cycle is loaded at the edge before.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      in_ready   <= 1'b1;
      match_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state      <= SHIFT;
          sout       <= head(in_data);
          shreg      <= advance(in_data);
          bit_cnt    <= '0;
          sout_valid <= 1'b1;
          busy       <= 1'b1;
          in_ready   <= 1'b0;
        end
        SHIFT: if (bit_cnt == BIT_W'(WIDTH - 1)) begin
          state   <= GAP;
          sout    <= 1'b0;
          gap_cnt <= '0;
        end else begin
          sout    <= head(shreg);
          shreg   <= advance(shreg);
          bit_cnt <= bit_cnt + 1'b1;
        end
        GAP: if (gap_cnt == GAP_W'(GAP_BITS - 1)) begin
          state      <= DONE;
          sout_valid <= 1'b0;
          word_done  <= 1'b1;
          match_cnt  <= run_cnt;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          word_done <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fed with every emitted bit; gap zeros only clear the odd-run flag.
  pair_run_counter #(.CNT_W(CNT_W)) u_pair_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .bit_en (sout_valid),
    .bit_in (sout),
    .count  (run_cnt)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench: an MSB-first and an LSB-first transmitter share stimulus.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready0, sout0, sout_valid0, busy0, word_done0;
  logic       in_ready1, sout1, sout_valid1, busy1, word_done1;
  logic [2:0] match_cnt0, match_cnt1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_mcnt = 0;
  bit mon_en = 1'b0;
  bit done_due = 1'b0;

  logic [1:0] bit_q[$];  // {lsb-first bit, msb-first bit}
  int         mcnt_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_pattern_tx #(.WIDTH(8), .GAP_BITS(1), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .sout(sout0), .sout_valid(sout_valid0),
    .busy(busy0), .word_done(word_done0), .match_cnt(match_cnt0)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP_BITS(1), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .sout(sout1), .sout_valid(sout_valid1),
    .busy(busy1), .word_done(word_done1), .match_cnt(match_cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every maximal run of L ones yields L/2 detector pulses.
  function automatic int pair_count(input logic [7:0] w);
    int run = 0;
    int tot = 0;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) run++;
      else begin
        tot += run / 2;
        run = 0;
      end
    end
    return tot + run / 2;
  endfunction

  function automatic void push_frame(input logic [7:0] w);
    for (int i = 0; i < 8; i++) bit_q.push_back({w[i], w[7-i]});
    bit_q.push_back(2'b00);
    mcnt_q.push_back(pair_count(w));
  endfunction

  // Monitor: compares every cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [1:0] e;
      bit exp_done;
      bit exp_busy;
      exp_done = done_due;
      done_due = 1'b0;
      exp_busy = (bit_q.size() != 0) || exp_done;
      chk("busy0", int'(busy0), int'(exp_busy));
      chk("busy1", int'(busy1), int'(exp_busy));
      chk("in_ready0", int'(in_ready0), int'(!exp_busy));
      chk("in_ready1", int'(in_ready1), int'(!exp_busy));
      chk("word_done0", int'(word_done0), int'(exp_done));
      chk("word_done1", int'(word_done1), int'(exp_done));
      if (exp_done) begin
        if (mcnt_q.size() == 0) chk("mcnt_queue_empty", 0, 1);
        else exp_mcnt = mcnt_q.pop_front();
      end
      chk("match_cnt0", int'(match_cnt0), exp_mcnt);
      chk("match_cnt1", int'(match_cnt1), exp_mcnt);
      chk("sout_valid0", int'(sout_valid0), int'(bit_q.size() != 0));
      chk("sout_valid1", int'(sout_valid1), int'(bit_q.size() != 0));
      if (bit_q.size() != 0) begin
        e = bit_q.pop_front();
        chk("sout_msb_first", int'(sout0), int'(e[0]));
        chk("sout_lsb_first", int'(sout1), int'(e[1]));
        if (bit_q.size() == 0) done_due = 1'b1;
      end else begin
        chk("idle_sout0", int'(sout0), 0);
        chk("idle_sout1", int'(sout1), 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] w, input bit hold, output int acc_cyc);
    bit acc = 1'b0;
    acc_cyc = -1;
    in_data = w;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      acc = in_ready0;
      tick(1);
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else begin
      push_frame(w);
      acc_cyc = cyc;
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bit_q.size() != 0 || done_due || mcnt_q.size() != 0) && k < 100) begin
      tick(1);
      k++;
    end
    if (k >= 100) chk("drain_timeout", 0, 1);
    tick(1);
  endtask

  initial begin
    int t, prev_t;
    logic [7:0] dir_words [6];
    dir_words = '{8'hFF, 8'h6E, 8'hAA, 8'h00, 8'h07, 8'h0F};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    tick(3);
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_sout_valid", int'(sout_valid0), 0);
    chk("rst_word_done", int'(word_done0), 0);
    chk("rst_match_cnt", int'(match_cnt1), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    foreach (dir_words[i]) send(dir_words[i], 1'b0, t);
    wait_idle();
    chk("mcnt_after_0F", int'(match_cnt0), 2);

    // Back-to-back with in_valid held: accepts must be one frame period apart.
    prev_t = -1;
    for (int i = 0; i < 6; i++) begin
      send((i % 2) ? 8'h3C : 8'hE7, 1'b1, t);
      if (prev_t >= 0) chk("b2b_spacing", t - prev_t, 11);
      prev_t = t;
    end
    in_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(0, 3));
      send(8'($urandom), 1'b0, t);
    end
    wait_idle();

    // Reset during the 4th payload bit abandons the frame.
    send(8'hFF, 1'b0, t);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bit_q.delete();
    mcnt_q.delete();
    done_due = 1'b0;
    exp_mcnt = 0;
    chk("midrst_sout_valid", int'(sout_valid0), 0);
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_match_cnt", int'(match_cnt0), 0);
    chk("midrst_word_done", int'(word_done0), 0);
    send(8'h0F, 1'b0, t);
    wait_idle();
    chk("post_rst_mcnt_0F", int'(match_cnt1), 2);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
